// File: rtl/shift_right_unit.sv
// shift_right_unit
//   Multi-cycle right shifter for srl/sra/srlv/srav. The operand is shifted
//   one bit per clock; the control unit pulses start, stalls on busy and
//   writes result back when done pulses.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high reset (highest priority)
//   start    request pulse; operands captured on the accepting edge
//   arith    1 = sign fill (sra), 0 = zero fill (srl)
//   shamt    shift amount, 0 .. 2^SHAMT_W-1
//   data_in  operand
//   result   shifted value, held until the next done
//   busy     high while an operation is in progress
//   done     one-cycle completion pulse
module shift_right_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               arith,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH-1:0]   result,
    output logic               busy,
    output logic               done
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   sreg;
    logic [SHAMT_W-1:0] cnt;
    logic               fill;

    // busy mirrors the SHIFT state but is kept as its own register so every
    // output comes straight from a flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            sreg   <= '0;
            cnt    <= '0;
            fill   <= 1'b0;
            result <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sreg  <= data_in;
                        cnt   <= shamt;
                        // Fill bit is latched once; later input changes are ignored.
                        fill  <= arith & data_in[WIDTH-1];
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // start is deliberately not looked at here.
                    if (cnt != '0) begin
                        sreg <= {fill, sreg[WIDTH-1:1]};
                        cnt  <= cnt - SHAMT_W'(1);
                    end else begin
                        result <= sreg;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_right_unit.sv
module tb_shift_right_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        arith;
    logic [4:0]  shamt;
    logic [31:0] data_in;
    logic [31:0] result;
    logic        busy;
    logic        done;

    shift_right_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .arith   (arith),
        .shamt   (shamt),
        .data_in (data_in),
        .result  (result),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge k settles, cyc == k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        int          e0;     // accepting edge
        int          edone;  // edge after which done is visible
    } op_t;

    op_t         q[$];
    logic [31:0] last_result = '0;
    int          last_edone  = 0;
    bit          skip        = 1'b1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // MIPS srl / sra semantics.
    function automatic logic [31:0] ref_shift(input logic a, input logic [4:0] n, input logic [31:0] d);
        if (a) return $signed(d) >>> n;
        return d >> n;
    endfunction

    // Monitor / scoreboard: compare against the queue on every falling edge.
    always @(negedge clk) begin
        if (!skip) begin
            logic exp_done;
            logic exp_busy;
            exp_done = (q.size() > 0) && (q[0].edone == cyc);
            check("done", {31'b0, done}, {31'b0, exp_done});
            if (exp_done) begin
                check("result_at_done", result, q[0].res);
                last_result = q[0].res;
                void'(q.pop_front());
            end else begin
                check("result_held", result, last_result);
            end
            exp_busy = (q.size() > 0) && (cyc >= q[0].e0) && (cyc < q[0].edone);
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
        end
    end

    task automatic scramble();
        arith   = 1'($urandom);
        shamt   = 5'($urandom);
        data_in = $urandom;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            scramble();
        end
    endtask

    // Called 1 time unit after a posedge; the next posedge is the candidate E0.
    task automatic issue(input logic a, input logic [4:0] n, input logic [31:0] d);
        int e;
        arith   = a;
        shamt   = n;
        data_in = d;
        start   = 1'b1;
        e = cyc + 1;
        if (e > last_edone) begin
            q.push_back('{res: ref_shift(a, n, d), e0: e, edone: e + int'(n) + 1});
            last_edone = e + int'(n) + 1;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble();
    endtask

    task automatic wait_idle();
        while (cyc < last_edone + 1) idle(1);
    endtask

    task automatic do_reset();
        skip  = 1'b1;
        reset = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        q.delete();
        last_result = '0;
        last_edone  = 0;
        skip = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        arith   = 1'b0;
        shamt   = '0;
        data_in = '0;
        do_reset();
        idle(2);

        // Logical shift
        issue(1'b0, 5'd4, 32'hF000_0000);
        wait_idle();
        // Maximum amount, both fills
        issue(1'b1, 5'd31, 32'h8000_0000);
        wait_idle();
        issue(1'b0, 5'd31, 32'h8000_0000);
        wait_idle();
        // Zero shift amount
        issue(1'b0, 5'd0, 32'h1234_5678);
        wait_idle();
        issue(1'b1, 5'd0, 32'h1234_5678);
        wait_idle();
        // start while busy: second request lands on E3 and must be ignored
        issue(1'b1, 5'd8, 32'hFFFF_0000);
        idle(2);
        issue(1'b0, 5'd1, 32'h0000_0001);
        wait_idle();
        // Reset mid-operation, sampled at E4
        issue(1'b0, 5'd10, 32'hDEAD_BEEF);
        idle(3);
        do_reset();
        issue(1'b0, 5'd8, 32'h0000_0100);
        wait_idle();
        // Back-to-back: start in the done cycle
        issue(1'b1, 5'd3, 32'h8765_4321);
        while (cyc < last_edone) idle(1);
        issue(1'b0, 5'd5, 32'hA5A5_A5A5);
        while (cyc < last_edone) idle(1);
        issue(1'b1, 5'd0, 32'hC000_0001);
        wait_idle();

        // Random mix: gaps of any length, including inside busy windows.
        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom), 5'($urandom), $urandom);
            if ($urandom_range(0, 24) == 0) begin
                idle(int'($urandom_range(0, 6)));
                do_reset();
            end else if ($urandom_range(0, 3) == 0) begin
                while (cyc < last_edone) idle(1);
            end else begin
                idle(int'($urandom_range(0, 40)));
            end
        end
        wait_idle();
        idle(3);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d operations never completed, expected 0", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_right_unit.md
Name: shift_right_unit

Overview:
- Multi-cycle right shifter for the MIPS datapath. Executes srl/sra (and srlv/srav, with the shift amount taken from a register) one bit per clock.
- This is the right-shift counterpart to the datapath's combinational left shifts.
- Sits beside the ALU. The control unit starts it with a one-cycle pulse, stalls while busy, and writes result back on done.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; shift range is 0 .. 2^SHAMT_W-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled on the rising edge of clk.
- arith  input  1  1 = arithmetic shift (sign fill); 0 = logical shift (zero fill).
- shamt  input  SHAMT_W  shift amount; captured together with start.
- data_in  input  WIDTH  operand; captured together with start.
- result  output  WIDTH  shifted value; held until the next done.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset:
  - Synchronous, active-high; the only sequential clear.
  - After reset: state=IDLE, result=0, busy=0, done=0, internal shift register=0, counter=0.
  - reset takes priority over start and over any in-flight operation.
- States: IDLE, SHIFT.
- IDLE:
  - busy=0.
  - On an edge with start=1:
    - sreg <= data_in, cnt <= shamt, fill <= arith & data_in[WIDTH-1].
    - state <= SHIFT.
  - Call this edge E0.
- SHIFT:
  - busy=1.
  - Each edge with cnt != 0: sreg <= {fill, sreg[WIDTH-1:1]}, cnt <= cnt-1.
  - Edge with cnt == 0: result <= sreg, done <= 1, state <= IDLE.
- done:
  - Registered, high for exactly one cycle, then cleared on the next edge.
  - Never asserted outside an operation.
- Latency:
  - For shift amount n, shifts occur at E1..En; result and done become visible after edge E(n+1).
  - Total latency is n+1 cycles.
  - n=0 gives result=data_in after 1 cycle.
- Fill bit: latched at E0 from data_in, not re-read; later changes to data_in, arith or shamt do not affect the operation in flight.
- start while busy=1: ignored. No queuing, no restart, no error flag.
- Back-to-back operation:
  - start may be high in the cycle in which done=1 (state is IDLE); it is accepted on that edge.
  - Minimum issue interval is n+2 cycles.
- result stability:
  - result changes only on the done edge or on reset.
  - During SHIFT, result still shows the previous result.
- Reset mid-operation: aborts; no done pulse; result returns to 0; the next start begins cleanly.
- Arithmetic rules:
  - Logical shift: upper n bits = 0.
  - Arithmetic shift: upper n bits = data_in[WIDTH-1].
  - The lower WIDTH-n bits equal data_in[WIDTH-1:n].
  - Matches MIPS srl/sra semantics exactly for n in 0..31.

Test Plan:
- Logical shift: arith=0, data_in=0xF0000000, shamt=4, start pulse → busy high for 5 cycles; done at E5; result=0x0F000000.
- Arithmetic shift, maximum amount: arith=1, data_in=0x80000000, shamt=31 → done at E32; result=0xFFFFFFFF. The same operation with arith=0 → result=0x00000001.
- Zero shift amount: shamt=0, data_in=0x12345678, either arith → done exactly 1 cycle after E0; result=0x12345678; busy high for 1 cycle only.
- start while busy: start shamt=8, data_in=0xFFFF0000, arith=1; pulse start again at E3 with data_in=0x1, shamt=1 → second request ignored; single done at E9; result=0xFFFFFF00.
- Reset mid-operation: start shamt=10; assert reset at E4 → busy=0, done never pulses, result=0. A subsequent start with data_in=0x100, shamt=8, arith=0 → result=0x00000001 at E9.
- Back-to-back: assert start in the done cycle of a previous operation → second operation accepted on that edge; its done arrives n+1 cycles later with the correct value; the first result is held until then.
